// File: rtl/xadc_filter_pkg.sv
// Shared constants and types for the XADC auxiliary-channel filter slot.
// Holds the register map offsets, the sample width and the alarm state encoding.
package xadc_filter_pkg;

    localparam int ADC_W = 12;

    localparam logic [4:0] REG_AVG0   = 5'd0;
    localparam logic [4:0] REG_MM0    = 5'd4;
    localparam logic [4:0] REG_THR0   = 5'd8;
    localparam logic [4:0] REG_STATUS = 5'd12;
    localparam logic [4:0] REG_IRQ_EN = 5'd13;
    localparam logic [4:0] REG_CTRL   = 5'd14;

    typedef enum logic {
        NORMAL = 1'b0,
        ALARM  = 1'b1
    } alarm_state_t;

endpackage

// File: rtl/xadc_chan_filter.sv
// One filter channel: boxcar average, raw min/max and a hysteresis alarm
// that is re-evaluated only when a fresh average has just been produced.
module xadc_chan_filter
    import xadc_filter_pkg::*;
#(
    parameter int AVG_LOG2 = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sample_en,
    input  logic             clear,
    input  logic [ADC_W-1:0] x,
    input  logic [ADC_W-1:0] hi_thr,
    input  logic [ADC_W-1:0] lo_thr,
    output logic [ADC_W-1:0] avg,
    output logic [ADC_W-1:0] min_val,
    output logic [ADC_W-1:0] max_val,
    output logic             live_alarm,
    output logic             alarm_set
);

    localparam int ACC_W = ADC_W + AVG_LOG2;
    // With AVG_LOG2 = 0 the counter degenerates to a single bit stuck at 0.
    localparam int CNT_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ADC_W-1:0] avg_q, avg_d;
    logic [ADC_W-1:0] min_q, min_d;
    logic [ADC_W-1:0] max_q, max_d;
    alarm_state_t     state_q, state_d;

    logic [ACC_W-1:0] sum;
    logic [ADC_W-1:0] avg_new;
    logic             done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            avg_q   <= '0;
            min_q   <= '1;
            max_q   <= '0;
            state_q <= NORMAL;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            avg_q   <= avg_d;
            min_q   <= min_d;
            max_q   <= max_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        avg_d     = avg_q;
        min_d     = min_q;
        max_d     = max_q;
        state_d   = state_q;
        alarm_set = 1'b0;
        done      = 1'b0;
        sum       = acc_q + ACC_W'(x);
        avg_new   = ADC_W'(sum >> AVG_LOG2);

        // A control clear discards any sample arriving in the same cycle.
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
            min_d = '1;
            max_d = '0;
        end else if (sample_en) begin
            if (x < min_q) min_d = x;
            if (x > max_q) max_d = x;
            if (cnt_q == CNT_LAST) begin
                done  = 1'b1;
                avg_d = avg_new;
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Thresholds are the registered values, so a write landing with done sees the old ones.
        if (done) begin
            case (state_q)
                NORMAL: begin
                    if (avg_new >= hi_thr) begin
                        state_d   = ALARM;
                        alarm_set = 1'b1;
                    end
                end
                ALARM: begin
                    if (avg_new <= lo_thr) state_d = NORMAL;
                end
                default: state_d = NORMAL;
            endcase
        end
    end

    assign avg        = avg_q;
    assign min_val    = min_q;
    assign max_val    = max_q;
    assign live_alarm = (state_q == ALARM);

endmodule

// File: rtl/xadc_filter_core.sv
// MMIO slot wrapping four XADC auxiliary-channel filters with sticky alarm
// status, per-channel interrupt enables and a single registered irq line.
module xadc_filter_core
    import xadc_filter_pkg::*;
#(
    parameter int         AVG_LOG2 = 4,
    parameter logic [4:0] CH0_ID   = 5'd19,
    parameter logic [4:0] CH1_ID   = 5'd26,
    parameter logic [4:0] CH2_ID   = 5'd18,
    parameter logic [4:0] CH3_ID   = 5'd27
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    input  logic        s_valid,
    input  logic [4:0]  s_channel,
    input  logic [15:0] s_data,
    output logic        irq
);

    logic [ADC_W-1:0] hi_thr_q [4];
    logic [ADC_W-1:0] hi_thr_d [4];
    logic [ADC_W-1:0] lo_thr_q [4];
    logic [ADC_W-1:0] lo_thr_d [4];
    logic [3:0]       status_q, status_d;
    logic [3:0]       irq_en_q, irq_en_d;
    logic             irq_q, irq_d;

    logic [ADC_W-1:0] avg_w [4];
    logic [ADC_W-1:0] min_w [4];
    logic [ADC_W-1:0] max_w [4];
    logic [3:0]       live_alarm;
    logic [3:0]       alarm_set;
    logic [3:0]       sample_en;
    logic [3:0]       w1c;
    logic [ADC_W-1:0] x;
    logic             wr_en;
    logic             ctrl_clear;
    logic             unused_inputs;

    assign x          = s_data[15:4];
    assign wr_en      = cs && write;
    assign ctrl_clear = wr_en && (addr == REG_CTRL) && wr_data[0];

    assign sample_en[0] = s_valid && (s_channel == CH0_ID);
    assign sample_en[1] = s_valid && (s_channel == CH1_ID);
    assign sample_en[2] = s_valid && (s_channel == CH2_ID);
    assign sample_en[3] = s_valid && (s_channel == CH3_ID);

    assign unused_inputs = ^{read, s_data[3:0], wr_data[31:28], wr_data[15:12]};

    for (genvar g = 0; g < 4; g++) begin : g_chan
        xadc_chan_filter #(
            .AVG_LOG2 (AVG_LOG2)
        ) u_chan (
            .clk        (clk),
            .reset_n    (reset_n),
            .sample_en  (sample_en[g]),
            .clear      (ctrl_clear),
            .x          (x),
            .hi_thr     (hi_thr_q[g]),
            .lo_thr     (lo_thr_q[g]),
            .avg        (avg_w[g]),
            .min_val    (min_w[g]),
            .max_val    (max_w[g]),
            .live_alarm (live_alarm[g]),
            .alarm_set  (alarm_set[g])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                hi_thr_q[i] <= '1;
                lo_thr_q[i] <= '0;
            end
            status_q <= '0;
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            hi_thr_q <= hi_thr_d;
            lo_thr_q <= lo_thr_d;
            status_q <= status_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        hi_thr_d = hi_thr_q;
        lo_thr_d = lo_thr_q;
        irq_en_d = irq_en_q;
        w1c      = '0;

        for (int i = 0; i < 4; i++) begin
            if (wr_en && (addr == REG_THR0 + 5'(i))) begin
                hi_thr_d[i] = wr_data[27:16];
                lo_thr_d[i] = wr_data[11:0];
            end
        end
        if (wr_en && (addr == REG_STATUS)) w1c = wr_data[3:0];
        if (wr_en && (addr == REG_IRQ_EN)) irq_en_d = wr_data[3:0];

        // A new alarm beats a simultaneous write-one-to-clear.
        status_d = (status_q & ~w1c) | alarm_set;
        irq_d    = |(status_q & irq_en_q);
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < 4; i++) begin
            if (addr == REG_AVG0 + 5'(i)) rd_data = {20'b0, avg_w[i]};
            if (addr == REG_MM0 + 5'(i))  rd_data = {4'b0, max_w[i], 4'b0, min_w[i]};
            if (addr == REG_THR0 + 5'(i)) rd_data = {4'b0, hi_thr_q[i], 4'b0, lo_thr_q[i]};
        end
        if (addr == REG_STATUS) rd_data = {24'b0, live_alarm, status_q};
        if (addr == REG_IRQ_EN) rd_data = {28'b0, irq_en_q};
    end

    assign irq = irq_q;

endmodule
